// File: rtl/audio_mem_scheduler.sv
// Record/playback sequencer and single-port arbiter for the shared audio BRAM.
// Owns mode FSM, BRAM address/we/din generation, recorded length and read pipeline.
module audio_mem_scheduler #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_btn,
    input  logic              play_btn,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [3:0]        bram_we,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              recording,
    output logic              playing,
    output logic              mem_full,
    output logic [ADDR_W:0]   rec_len
);

    typedef enum logic [1:0] {IDLE, REC, PLAY, DRAIN} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state, next_state;
    logic              rec_q, play_q, rec_edge, play_edge;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   len_q;
    logic              wr_blank, rd_done;
    logic [1:0]        vld_pipe;
    logic              wr_accept, rd_accept, rd_busy, rd_last;

    // A read stays outstanding from accept through its ack cycle.
    assign rd_busy   = (|vld_pipe) | rd_ack;
    assign wr_accept = (state == REC) && wr_req && !wr_ack && !wr_blank && (len_q < DEPTH_L);
    assign rd_accept = (state == PLAY) && rd_req && !rd_busy && !rd_done;
    assign rd_last   = vld_pipe[1] && rd_done;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (rec_edge)                           next_state = REC;
                else if (play_edge && len_q != '0)      next_state = PLAY;
            end
            REC: begin
                if (rec_edge || (wr_accept && len_q == DEPTH_L - 1'b1)) next_state = IDLE;
            end
            PLAY: begin
                if (rd_last)        next_state = IDLE;
                else if (play_edge) next_state = DRAIN;
            end
            DRAIN: begin
                if (vld_pipe == '0) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        recording = (state == REC);
        playing   = (state == PLAY);
        mem_full  = (len_q == DEPTH_L);
        rec_len   = len_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q     <= 1'b0;
            play_q    <= 1'b0;
            rec_edge  <= 1'b0;
            play_edge <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            len_q     <= '0;
            wr_blank  <= 1'b0;
            rd_done   <= 1'b0;
            vld_pipe  <= '0;
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            rd_data   <= '0;
            bram_addr <= '0;
            bram_we   <= 4'h0;
            bram_din  <= '0;
        end else begin
            rec_q     <= rec_btn;
            play_q    <= play_btn;
            rec_edge  <= rec_btn & ~rec_q;
            play_edge <= play_btn & ~play_q;

            wr_ack   <= wr_accept;
            wr_blank <= wr_ack;
            bram_we  <= wr_accept ? 4'hF : 4'h0;

            // Read pipe: addr issue -> BRAM latency -> capture with ack.
            vld_pipe <= {vld_pipe[0], rd_accept};
            rd_ack   <= vld_pipe[1];
            if (vld_pipe[1]) rd_data <= bram_dout;

            if (wr_accept) begin
                bram_addr <= wr_ptr;
                bram_din  <= wr_data;
                wr_ptr    <= wr_ptr + 1'b1;
                len_q     <= len_q + 1'b1;
            end else if (rd_accept) begin
                bram_addr <= rd_ptr;
                rd_ptr    <= rd_ptr + 1'b1;
                // Pointer may wrap at full depth, so remember the last issue explicitly.
                if ({1'b0, rd_ptr} == len_q - 1'b1) rd_done <= 1'b1;
            end

            if (state == IDLE && next_state == REC) begin
                wr_ptr <= '0;
                len_q  <= '0;
            end
            if (state == IDLE && next_state == PLAY) begin
                rd_ptr  <= '0;
                rd_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_mem_scheduler.sv
// Directed bench for audio_mem_scheduler with a behavioural BRAM and write/read scoreboards.
module tb_audio_mem_scheduler;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset, rec_btn, play_btn, wr_req, rd_req;
    logic [DW-1:0] wr_data;
    logic          wr_ack, rd_ack;
    logic [DW-1:0] rd_data, bram_din, bram_dout;
    logic [AW-1:0] bram_addr;
    logic [3:0]    bram_we;
    logic          recording, playing, mem_full;
    logic [AW:0]   rec_len;

    audio_mem_scheduler #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rec_btn(rec_btn), .play_btn(play_btn),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
        .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
        .recording(recording), .playing(playing), .mem_full(mem_full), .rec_len(rec_len)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bram_we == 4'hF) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    wr_exp_t       wr_q[$];
    logic [DW-1:0] rd_q[$];
    int            ack_cyc[$];
    wr_exp_t       w_e;
    logic [DW-1:0] r_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write issue and read ack is matched against the queues.
    always @(negedge clk) begin
        if (bram_we != 4'h0 || wr_ack) begin
            if (wr_q.size() == 0) chk("unexpected_write", 64'(wr_q.size()), 64'd1);
            else begin
                w_e = wr_q.pop_front();
                chk("wr_addr", 64'(bram_addr), 64'(w_e.addr));
                chk("wr_data", 64'(bram_din), 64'(w_e.data));
                chk("wr_we", 64'(bram_we), 64'hF);
                chk("wr_ack_with_we", 64'(wr_ack), 64'd1);
            end
        end
        if (rd_ack) begin
            ack_cyc.push_back(cyc);
            if (rd_q.size() == 0) chk("unexpected_rd_ack", 64'(rd_q.size()), 64'd1);
            else begin
                r_e = rd_q.pop_front();
                chk("rd_data", 64'(rd_data), 64'(r_e));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d, input logic [AW-1:0] a, output int lat);
        logic ok;
        ok  = 1'b0;
        lat = 0;
        wr_q.push_back('{a, d});
        wr_data = d;
        wr_req  = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            lat++;
            if (wr_ack) ok = 1'b1;
        end
        chk("wr_ack_timeout", 64'(ok), 64'd1);
        wr_req = 1'b0;
        tick();
        chk("wr_ack_pulse", 64'(wr_ack), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b, acks;
        reset = 1'b1; rec_btn = 1'b0; play_btn = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
        tick(3);
        chk("rst_wr_ack", 64'(wr_ack), 0);
        chk("rst_rd_ack", 64'(rd_ack), 0);
        chk("rst_rd_data", 64'(rd_data), 0);
        chk("rst_addr", 64'(bram_addr), 0);
        chk("rst_we", 64'(bram_we), 0);
        chk("rst_din", 64'(bram_din), 0);
        chk("rst_recording", 64'(recording), 0);
        chk("rst_playing", 64'(playing), 0);
        chk("rst_full", 64'(mem_full), 0);
        chk("rst_len", 64'(rec_len), 0);
        reset = 1'b0;
        tick();

        // Play with nothing recorded stays idle.
        play_btn = 1'b1; tick(3);
        chk("play_empty_idle", 64'(playing), 0);
        play_btn = 1'b0; tick();

        // Record entry latency: visible two cycles after the edge; level does not re-toggle.
        rec_btn = 1'b1; tick();
        chk("rec_lat_t1", 64'(recording), 0);
        tick();
        chk("rec_lat_t2", 64'(recording), 1);
        tick(3);
        chk("rec_level_ignored", 64'(recording), 1);
        rec_btn = 1'b0; tick();

        play_btn = 1'b1; tick(3);
        chk("play_in_rec_rec", 64'(recording), 1);
        chk("play_in_rec_play", 64'(playing), 0);
        play_btn = 1'b0; tick();

        write_word(32'hA5A5_0001, 10'd0, lat); chk("wr_lat_first", 64'(lat), 1);
        write_word(32'hA5A5_0002, 10'd1, lat); chk("wr_lat_blank", 64'(lat), 2);
        write_word(32'hA5A5_0003, 10'd2, lat);
        chk("len_3", 64'(rec_len), 3);

        rec_btn = 1'b1; tick(2);
        chk("rec_stop", 64'(recording), 0);
        rec_btn = 1'b0; tick();

        // Playback to end with rd_req held high throughout.
        rd_q.push_back(32'hA5A5_0001);
        rd_q.push_back(32'hA5A5_0002);
        rd_q.push_back(32'hA5A5_0003);
        ack_cyc.delete();
        rd_req = 1'b1; play_btn = 1'b1; b = cyc;
        tick(); play_btn = 1'b0;
        tick(30);
        chk("play_ack_count", 64'(ack_cyc.size()), 3);
        if (ack_cyc.size() == 3) begin
            chk("play_ack0_cyc", 64'(ack_cyc[0] - b), 5);
            chk("play_ack1_gap", 64'(ack_cyc[1] - ack_cyc[0]), 4);
            chk("play_ack2_gap", 64'(ack_cyc[2] - ack_cyc[1]), 4);
        end
        chk("play_end_idle", 64'(playing), 0);
        chk("play_len_kept", 64'(rec_len), 3);
        chk("rd_data_hold", 64'(rd_data), 64'hA5A5_0003);
        rd_req = 1'b0; tick();

        // Simultaneous edges: record wins and clears the length.
        rec_btn = 1'b1; play_btn = 1'b1; tick(2);
        chk("simul_rec", 64'(recording), 1);
        chk("simul_play", 64'(playing), 0);
        chk("simul_len_clr", 64'(rec_len), 0);
        rec_btn = 1'b0; play_btn = 1'b0; tick();

        for (int i = 0; i < DEPTH; i++) write_word(32'hC000_0000 | DW'(i), AW'(i), lat);
        chk("full_flag", 64'(mem_full), 1);
        chk("full_len", 64'(rec_len), 1024);
        chk("full_idle", 64'(recording), 0);
        acks = 0;
        wr_req = 1'b1; wr_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr_ack) acks++;
        end
        chk("full_no_ack", 64'(acks), 0);
        chk("full_wr_q_empty", 64'(wr_q.size()), 0);
        wr_req = 1'b0; tick();

        // Stop playback with a read in flight: that read completes, nothing after.
        rd_q.push_back(32'hC000_0000);
        ack_cyc.delete();
        rd_req = 1'b1; play_btn = 1'b1; b = cyc;
        tick(); play_btn = 1'b0;
        tick(2);
        play_btn = 1'b1; tick();
        chk("drain_still_play", 64'(playing), 1);
        play_btn = 1'b0; tick();
        chk("drain_not_play", 64'(playing), 0);
        tick(20);
        chk("drain_ack_count", 64'(ack_cyc.size()), 1);
        if (ack_cyc.size() == 1) chk("drain_ack_cyc", 64'(ack_cyc[0] - b), 5);
        chk("drain_idle", 64'(playing), 0);
        chk("drain_len_kept", 64'(rec_len), 1024);
        rd_req = 1'b0; tick();

        // Reset the cycle after a write accept.
        rec_btn = 1'b1; tick(2);
        rec_btn = 1'b0;
        wr_q.push_back('{10'd0, 32'h1234_5678});
        wr_data = 32'h1234_5678; wr_req = 1'b1;
        tick();
        chk("rst_mid_ack_seen", 64'(wr_ack), 1);
        reset = 1'b1; tick();
        chk("rst_mid_wr_ack", 64'(wr_ack), 0);
        chk("rst_mid_we", 64'(bram_we), 0);
        chk("rst_mid_addr", 64'(bram_addr), 0);
        chk("rst_mid_din", 64'(bram_din), 0);
        chk("rst_mid_rec", 64'(recording), 0);
        chk("rst_mid_len", 64'(rec_len), 0);
        chk("rst_mid_full", 64'(mem_full), 0);
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wr_ack) acks++;
        end
        chk("rst_mid_no_ack", 64'(acks), 0);
        chk("rst_mid_len_after", 64'(rec_len), 0);
        wr_req = 1'b0; tick(2);

        chk("end_wr_q_empty", 64'(wr_q.size()), 0);
        chk("end_rd_q_empty", 64'(rd_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
